// File: rtl/spi_word_fifo.sv
// Single-clock word FIFO between the AXI register interface and the SPI controller.
// Registered read data, occupancy count, almost-full and sticky overflow/underflow flags.
module spi_word_fifo #(
  parameter int DATA_WIDTH        = 32,
  parameter int DEPTH             = 256,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 4
) (
  input  logic                     axi_clk,
  input  logic                     reset_b,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clear_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]         wp_r;
  logic [AW-1:0]         rp_r;
  logic [CW-1:0]         count_r;
  logic [DATA_WIDTH-1:0] dout_r;
  logic                  overflow_r;
  logic                  underflow_r;

  logic full_s;
  logic empty_s;
  logic wr_acc_s;
  logic rd_acc_s;
  logic ovf_evt_s;
  logic udf_evt_s;

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty_s   = (count_r == {CW{1'b0}});
  assign wr_acc_s  = wr_en && !full_s && !flush;
  assign rd_acc_s  = rd_en && !empty_s && !flush;
  assign ovf_evt_s = wr_en && full_s && !flush;
  assign udf_evt_s = rd_en && empty_s && !flush;

  assign full        = full_s;
  assign empty       = empty_s;
  assign almost_full = (count_r >= CW'(ALMOST_FULL_LEVEL));
  assign count       = count_r;
  assign dout        = dout_r;
  assign overflow    = overflow_r;
  assign underflow   = underflow_r;

  // Storage array; contents survive flush and reset by design.
  always_ff @(posedge axi_clk) begin
    if (wr_acc_s) begin
      mem_r[wp_r] <= din;
    end
  end

  // Pointers and occupancy; flush acts as the synchronous soft reset.
  always_ff @(posedge axi_clk or negedge reset_b) begin
    if (!reset_b) begin
      wp_r    <= {AW{1'b0}};
      rp_r    <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (flush) begin
      wp_r    <= {AW{1'b0}};
      rp_r    <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wp_r <= wp_r + AW'(1);
      end
      if (rd_acc_s) begin
        rp_r <= rp_r + AW'(1);
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered read data; holds whenever no read is accepted.
  always_ff @(posedge axi_clk or negedge reset_b) begin
    if (!reset_b) begin
      dout_r <= {DATA_WIDTH{1'b0}};
    end else if (rd_acc_s) begin
      dout_r <= mem_r[rp_r];
    end else begin
      dout_r <= dout_r;
    end
  end

  // Sticky error flags; a new event beats clear_err in the same cycle.
  always_ff @(posedge axi_clk or negedge reset_b) begin
    if (!reset_b) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (ovf_evt_s) begin
        overflow_r <= 1'b1;
      end else if (clear_err) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (udf_evt_s) begin
        underflow_r <= 1'b1;
      end else if (clear_err) begin
        underflow_r <= 1'b0;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

endmodule

// File: tb/tb_spi_word_fifo.sv
// Scoreboard bench for spi_word_fifo at DEPTH=8, ALMOST_FULL_LEVEL=4.
module tb_spi_word_fifo;

  localparam int DW  = 32;
  localparam int DEP = 8;
  localparam int AFL = 4;

  logic          axi_clk;
  logic          reset_b;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          full;
  logic          almost_full;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          empty;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;
  logic          clear_err;

  int            err_cnt_r;
  int            chk_cnt_r;
  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_udf;

  spi_word_fifo #(.DATA_WIDTH(DW), .DEPTH(DEP), .ALMOST_FULL_LEVEL(AFL)) dut (
    .axi_clk     (axi_clk),
    .reset_b     (reset_b),
    .flush       (flush),
    .wr_en       (wr_en),
    .din         (din),
    .full        (full),
    .almost_full (almost_full),
    .rd_en       (rd_en),
    .dout        (dout),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .clear_err   (clear_err)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    chk_cnt_r++;
    if (got !== exp) begin
      err_cnt_r++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = sb_q.size();
    check_val("dout",        dout,                m_dout);
    check_val("count",       DW'(count),          DW'(sz));
    check_val("empty",       DW'(empty),          DW'(sz == 0));
    check_val("full",        DW'(full),           DW'(sz == DEP));
    check_val("almost_full", DW'(almost_full),    DW'(sz >= AFL));
    check_val("overflow",    DW'(overflow),       DW'(m_ovf));
    check_val("underflow",   DW'(underflow),      DW'(m_udf));
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // One clock: drive, predict from pre-edge model state, then compare after the edge.
  task automatic cycle(input logic wr, input logic rd, input logic [DW-1:0] d,
                       input logic fl, input logic ce);
    logic was_full;
    logic was_empty;
    wr_en     = wr;
    rd_en     = rd;
    din       = d;
    flush     = fl;
    clear_err = ce;
    was_full  = (sb_q.size() == DEP);
    was_empty = (sb_q.size() == 0);
    @(posedge axi_clk);
    #1;
    if (fl) begin
      sb_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (rd && !was_empty) m_dout = sb_q.pop_front();
      if (wr && !was_full)  sb_q.push_back(d);
      if (wr && was_full)   m_ovf = 1'b1;
      else if (ce)          m_ovf = 1'b0;
      if (rd && was_empty)  m_udf = 1'b1;
      else if (ce)          m_udf = 1'b0;
    end
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    flush     = 1'b0;
    clear_err = 1'b0;
    check_all();
  endtask

  task automatic wr_word(input logic [DW-1:0] d);
    cycle(1'b1, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic rd_word();
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
  endtask

  initial begin
    err_cnt_r = 0;
    chk_cnt_r = 0;
    reset_b   = 1'b0;
    flush     = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    din       = '0;
    clear_err = 1'b0;
    model_reset();
    repeat (3) @(posedge axi_clk);
    #1;
    check_all();
    reset_b = 1'b1;
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Basic write/read order
    wr_word(32'hA5A5_0001);
    wr_word(32'hA5A5_0002);
    rd_word();
    rd_word();

    // Fill, wrap, drain
    for (int i = 0; i < 8; i++) wr_word(DW'(i));
    for (int i = 0; i < 3; i++) rd_word();
    for (int i = 8; i < 11; i++) wr_word(DW'(i));
    for (int i = 0; i < 8; i++) rd_word();

    // Overflow with simultaneous read, then clear_err
    for (int i = 0; i < 8; i++) wr_word(32'h0000_0100 + DW'(i));
    cycle(1'b1, 1'b1, 32'h0000_DEAD, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) rd_word();

    // Underflow with simultaneous write
    cycle(1'b1, 1'b1, 32'h0000_1234, 1'b0, 1'b0);
    rd_word();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Event beats clear_err in the same cycle
    cycle(1'b0, 1'b1, '0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Steady streaming at count 3
    for (int i = 0; i < 3; i++) wr_word(32'h0000_2000 + DW'(i));
    for (int i = 3; i < 23; i++) cycle(1'b1, 1'b1, 32'h0000_2000 + DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) rd_word();

    // Flush with a concurrent write, after raising an error flag
    rd_word();
    for (int i = 0; i < 5; i++) wr_word(32'h0000_3000 + DW'(i));
    cycle(1'b1, 1'b0, 32'h0000_3FFF, 1'b1, 1'b0);
    wr_word(32'h0000_4000);
    wr_word(32'h0000_4001);

    // Asynchronous reset mid-cycle
    #2;
    reset_b = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge axi_clk);
    #2;
    reset_b = 1'b1;
    wr_word(32'h0000_5000);
    rd_word();

    $display("Result: errors=%0d of %0d checks", err_cnt_r, chk_cnt_r);
    $finish;
  end

endmodule
